// File: rtl/hack_pkg.sv
// Shared types and instruction-field constants for the Hack CPU control stage.
package hack_pkg;

  localparam int WORD_W = 16;

  localparam int IS_C   = 15;
  localparam int A_BIT  = 12;
  localparam int CTL_HI = 11;
  localparam int CTL_LO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;

  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/hack_cpu_ctrl_jump_cond.sv
// Jump decision from the three jump bits and the ALU sign/zero flags.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: fetch handshake, A/D/PC registers, ALU drive, M write.
// Optional halt-on-self-jump detection enabled by defining HACK_HALT_DETECT_EN.
//
// state | meaning
// FETCH | instr_ready=1, wait for instr_valid, latch ir
// EXEC  | drive ALU, commit A/D/PC, maybe launch M write
// WRITE | hold write_m/out_m/address_m until mem_ready
// HALT  | self-jump seen (HACK_HALT_DETECT_EN only); only reset exits
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int          PC_W     = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  input  logic [15:0]       in_m,
  output logic [PC_W-1:0]   address_m,
  output logic [15:0]       out_m,
  output logic              write_m,
  input  logic              mem_ready,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [5:0]        alu_ctl,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic              halted
);

  logic [WORD_W-1:0] a_reg;
  logic [WORD_W-1:0] d_reg;
  logic [WORD_W-1:0] ir;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   wr_addr;
  logic [PC_W-1:0]   a_addr;
  logic [PC_W-1:0]   pc_seq;
  logic              halt_pending;
  logic              halt_hit;
  logic              take;
  state_t            state;

  assign a_addr = a_reg[PC_W-1:0];
  assign pc_seq = pc_reg + PC_W'(1);

  hack_jump_cond u_jump_cond (
    .j    (ir[2:0]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

`ifdef HACK_HALT_DETECT_EN
  assign halt_hit = (ir[2:0] == JMP) && (a_addr == pc_reg);
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_FETCH;
      a_reg        <= '0;
      d_reg        <= '0;
      ir           <= '0;
      pc_reg       <= PC_W'(RESET_PC);
      wr_addr      <= '0;
      out_m        <= '0;
      write_m      <= 1'b0;
      halt_pending <= 1'b0;
      halted       <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!ir[IS_C]) begin
            a_reg  <= {1'b0, ir[WORD_W-2:0]};
            pc_reg <= pc_seq;
            state  <= ST_FETCH;
          end else begin
            if (ir[DEST_A]) a_reg <= alu_out;
            if (ir[DEST_D]) d_reg <= alu_out;
            // jump target and write address both use A before this update
            pc_reg <= take ? a_addr : pc_seq;
            if (ir[DEST_M]) begin
              out_m        <= alu_out;
              wr_addr      <= a_addr;
              write_m      <= 1'b1;
              halt_pending <= halt_hit;
              state        <= ST_WRITE;
            end else if (halt_hit) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            write_m <= 1'b0;
            if (halt_pending) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
`ifdef HACK_HALT_DETECT_EN
        ST_HALT: state <= ST_HALT;
`endif
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign instr_ready = (state == ST_FETCH);
  assign pc          = pc_reg;
  assign address_m   = (state == ST_WRITE) ? wr_addr : a_addr;
  assign alu_x       = d_reg;
  assign alu_y       = ir[A_BIT] ? in_m : a_reg;
  assign alu_ctl     = ir[CTL_HI:CTL_LO];

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: directed cases plus random programs vs an ISA-level model.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] pc;
  logic [15:0] in_m;
  logic [14:0] address_m;
  logic [15:0] out_m;
  logic        write_m;
  logic        mem_ready;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctl;
  logic        alu_zr, alu_ng, halted;

  logic [15:0] mem [0:32767];

  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  int n_checks = 0;
  int n_errors = 0;

  hack_cpu_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .in_m(in_m), .address_m(address_m),
    .out_m(out_m), .write_m(write_m), .mem_ready(mem_ready), .alu_x(alu_x),
    .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_out(alu_out), .alu_zr(alu_zr),
    .alu_ng(alu_ng), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign in_m    = mem[address_m];
  assign alu_out = hack_alu(alu_x, alu_y, alu_ctl);
  assign alu_zr  = (alu_out == 16'h0);
  assign alu_ng  = alu_out[15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    instr       = 16'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_a   = 16'h0;
    m_d   = 16'h0;
    m_pc  = 15'h0;
  endtask

  // Runs one instruction through the DUT and the ISA model, checking every stage.
  task automatic exec_instr(input logic [15:0] ins, input int wait_cycles, input int idle);
    int          guard;
    logic [15:0] res, y;
    logic [14:0] old_a;
    logic        take;
    instr_valid = 1'b0;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("fetch_ready", instr_ready, 1);
    if (!instr_ready) return;
    for (int i = 0; i < idle; i++) @(negedge clk);
    chk("pc_fetch", pc, m_pc);
    instr       = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'($urandom_range(0, 1));
    instr       = 16'($urandom);
    chk("exec_ready", instr_ready, 0);
    chk("exec_addr", address_m, m_a[14:0]);
    chk("alu_ctl", alu_ctl, ins[11:6]);
    old_a = m_a[14:0];
    res   = 16'h0;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      y = ins[12] ? mem[old_a] : m_a;
      chk("alu_x", alu_x, m_d);
      chk("alu_y", alu_y, y);
      res  = hack_alu(m_d, y, ins[11:6]);
      take = ($signed(res) < 0 && ins[2]) || (res == 16'h0 && ins[1]) ||
             ($signed(res) > 0 && ins[0]);
      if (ins[5]) m_a = res;
      if (ins[4]) m_d = res;
      m_pc = take ? old_a : m_pc + 15'd1;
    end
    @(negedge clk);
    if (ins[15] && ins[3]) begin
      for (int i = 0; i <= wait_cycles; i++) begin
        chk("write_m_hold", write_m, 1);
        chk("addr_m_hold", address_m, old_a);
        chk("out_m_hold", out_m, res);
        chk("write_not_ready", instr_ready, 0);
        instr_valid = 1'($urandom_range(0, 1));
        mem_ready   = (i == wait_cycles);
        @(negedge clk);
      end
      mem_ready  = 1'b0;
      mem[old_a] = res;
    end
    instr_valid = 1'b0;
    chk("done_ready", instr_ready, 1);
    chk("write_idle", write_m, 0);
    chk("pc_after", pc, m_pc);
    chk("reg_a", dut.a_reg, m_a);
    chk("reg_d", dut.d_reg, m_d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ins;
    logic [14:0] p0;
    int          guard;
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 3 + 1);

    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_write_m", write_m, 0);
    chk("rst_out_m", out_m, 0);
    chk("rst_halted", halted, 0);
    chk("rst_a", dut.a_reg, 0);
    chk("rst_d", dut.d_reg, 0);

    exec_instr(16'h0005, 0, 1);
    chk("t1_a", dut.a_reg, 16'h0005);
    chk("t1_pc", pc, 15'd1);
    exec_instr(16'hEC10, 0, 0);
    chk("t2_d", dut.d_reg, 16'h0005);
    chk("t2_pc", pc, 15'd2);

    exec_instr(16'h0007, 0, 0);
    exec_instr(16'hEC10, 0, 0);
    exec_instr(16'h0010, 0, 0);
    exec_instr(16'hE308, 3, 0);
    chk("t3_mem", mem[16'h0010], 16'h0007);

    exec_instr(16'h0000, 0, 0);
    exec_instr(16'hEC10, 0, 0);
    exec_instr(16'h0020, 0, 0);
    exec_instr(16'hE302, 0, 0);
    chk("jeq_taken", pc, 15'h0020);
    exec_instr(16'h0007, 0, 0);
    exec_instr(16'hEC10, 0, 0);
    exec_instr(16'h0020, 0, 0);
    p0 = m_pc;
    exec_instr(16'hE302, 0, 0);
    chk("jeq_not_taken", pc, p0 + 15'd1);

    exec_instr(16'h7FFF, 0, 0);
    exec_instr(16'hEA87, 0, 0);
    chk("jmp_7fff", pc, 15'h7FFF);
    exec_instr(16'h0001, 0, 0);
    chk("pc_wrap", pc, 15'h0000);

    // AM=D+1;JMP must jump to the old A
    exec_instr(16'h0030, 0, 0);
    exec_instr(16'hE7EF, 1, 0);
    chk("jmp_old_a", pc, 15'h0030);

    // reset while a write is pending
    exec_instr(16'h0009, 0, 0);
    exec_instr(16'hEC10, 0, 0);
    instr       = 16'hE308;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_write", write_m, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    chk("wrst_write_m", write_m, 0);
    chk("wrst_pc", pc, 0);
    chk("wrst_a", dut.a_reg, 0);
    chk("wrst_d", dut.d_reg, 0);
    chk("wrst_ready", instr_ready, 1);
    chk("wrst_mem_kept", mem[9], 16'(9 * 3 + 1));

    // self-jump at pc=4 with A=4
    exec_instr(16'h0003, 0, 0);
    exec_instr(16'h0003, 0, 0);
    exec_instr(16'h0003, 0, 0);
    exec_instr(16'h0004, 0, 0);
    chk("pre_halt_pc", pc, 15'd4);
`ifdef HACK_HALT_DETECT_EN
    instr       = 16'hEA87;
    instr_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("halt_flag", halted, 1);
      chk("halt_ready", instr_ready, 0);
      chk("halt_pc", pc, 15'd4);
      @(negedge clk);
    end
    do_reset();
    chk("halt_rst", halted, 0);
`else
    exec_instr(16'hEA87, 0, 0);
    chk("selfjmp_pc", pc, 15'd4);
    chk("selfjmp_halted", halted, 0);
    exec_instr(16'hEA87, 0, 0);
    chk("selfjmp_pc2", pc, 15'd4);
`endif

    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 4)
        ins = {1'b0, 15'($urandom_range(0, 63))};
      else
        ins = {3'b111, 1'($urandom), 6'($urandom), 3'($urandom), 3'($urandom)};
`ifdef HACK_HALT_DETECT_EN
      if (ins[15] && ins[2:0] == 3'b111 && m_a[14:0] == m_pc) ins[2:0] = 3'b000;
`endif
      exec_instr(ins, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    guard = 0;
    chk("final_halted", halted, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
